rom_sample_reader: RTL and testbench

- Reader end of the music ROM interface. Walks the 24-bit ROM address space from a start to an end address at a fixed sample rate and latches each 8-bit byte.
- Delivers each byte downstream, to the PWM/DAC stage, over a valid/ready handshake.
- Supports play, pause, stop, loop and end-of-track signalling.
- The ROM (ROM_musicas) is purely combinational: data is valid in the same cycle the address is stable.

---
 rtl/music_pkg.sv | 16 +
 rtl/sample_tick_gen.sv | 39 +++
 rtl/rom_sample_reader.sv | 139 +++++++++++++
 tb/tb_rom_sample_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the music ROM playback path.
package music_pkg;

   localparam int unsigned DEF_ADDR_W  = 24;
   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_CLK_DIV = 6250;  // 50 MHz system clock / 8 kHz sample rate

   typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_e;

   // Track boundaries inside the music ROM image (end addresses are inclusive)
   localparam logic [DEF_ADDR_W-1:0] TRACK0_START = 24'd0;
   localparam logic [DEF_ADDR_W-1:0] TRACK0_END   = 24'd5;
   localparam logic [DEF_ADDR_W-1:0] TRACK1_START = 24'd20000;
   localparam logic [DEF_ADDR_W-1:0] TRACK1_END   = 24'd20000;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled, one-cycle tick on the last count.
module sample_tick_gen
   import music_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = en & (cnt_q == CNT_MAX);

   // Holding the count while disabled is what lets a pause resume mid-period
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rom_sample_reader.sv
// Walks a ROM address range at the sample rate and hands each byte downstream
// over a valid/ready handshake, with play/pause/stop/loop control.
module rom_sample_reader
   import music_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   state_e state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [DATA_W-1:0] data_d;
   logic valid_d, done_d, overrun_d;
   logic tick, at_end;

   // A tick coinciding with stop is suppressed at the source
   sample_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    ((state_q == PLAY) & ~stop),
      .clr   (stop | (state_q == IDLE)),
      .tick  (tick)
   );

   assign at_end = (ptr_q == end_q);
   assign busy   = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      start_d   = start_q;
      end_d     = end_q;
      data_d    = sample_data;
      valid_d   = sample_valid;
      done_d    = 1'b0;
      overrun_d = overrun;

      if (sample_valid && sample_ready) begin
         valid_d = 1'b0;
      end

      // Newest sample always wins; an unconsumed one is flagged, not preserved
      if (tick) begin
         data_d  = rom_data;
         valid_d = 1'b1;
         if (sample_valid && !sample_ready) begin
            overrun_d = 1'b1;
         end
         if (at_end) begin
            if (loop_en) begin
               ptr_d = start_q;
            end else begin
               done_d = 1'b1;
            end
         end else begin
            ptr_d = ptr_q + 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (play && !pause && !stop) begin
               state_d = PLAY;
               start_d = start_addr;
               end_d   = end_addr;
               ptr_d   = start_addr;
            end
         end
         PLAY: begin
            if (stop) begin
               state_d = IDLE;
            end else if (tick && at_end && !loop_en) begin
               state_d = IDLE;
            end else if (pause) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (!pause && play) begin
               state_d = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase

      if (stop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         start_q      <= '0;
         end_q        <= '0;
         rom_addr     <= '0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         done         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         start_q      <= start_d;
         end_q        <= end_d;
         rom_addr     <= ptr_q;
         sample_data  <= data_d;
         sample_valid <= valid_d;
         done         <= done_d;
         overrun      <= overrun_d;
      end
   end

endmodule

// File: tb/tb_rom_sample_reader.sv
// Directed and randomized checks of rom_sample_reader against a track-level model.
module tb_rom_sample_reader;
   import music_pkg::*;

   localparam int unsigned AW  = 24;
   localparam int unsigned DW  = 8;
   localparam int unsigned DIV = 4;

   logic          clk = 1'b0;
   logic          rst_n, play, pause, stop, loop_en, sample_ready;
   logic [AW-1:0] start_addr, end_addr, rom_addr;
   logic [DW-1:0] rom_data, sample_data;
   logic          sample_valid, busy, done, overrun;
   logic [7:0]    salt;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   // ROM image: fixed bytes for the known tracks, a salted hash elsewhere
   function automatic logic [7:0] rom_model(input logic [AW-1:0] a, input logic [7:0] s);
      case (a)
         24'd0:     return 8'h55;
         24'd1:     return 8'h5C;
         24'd2:     return 8'h63;
         24'd3:     return 8'h6A;
         24'd4:     return 8'h78;
         24'd5:     return 8'h85;
         24'd20000: return 8'h33;
         default:   return a[7:0] ^ a[15:8] ^ a[23:16] ^ s;
      endcase
   endfunction

   assign rom_data = rom_model(rom_addr, salt);

   rom_sample_reader #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .CLK_DIV (DIV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .play         (play),
      .pause        (pause),
      .stop         (stop),
      .loop_en      (loop_en),
      .start_addr   (start_addr),
      .end_addr     (end_addr),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   // Record every accepted sample and every done pulse
   always @(negedge clk) begin
      if (rst_n && sample_valid && sample_ready) got.push_back(sample_data);
      if (rst_n && done) done_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic play_pulse();
      play = 1'b1;
      step(1);
      play = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         step(1);
         k++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   // Expected byte sequence of a track: consecutive addresses with 24-bit wrap
   task automatic build_exp(input logic [AW-1:0] first, input int len);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(rom_model(first + AW'(i), salt));
   endtask

   task automatic check_seq(input string tag, input int gb);
      logic [7:0] g;
      check({tag, "_len"}, 32'(got.size() - gb), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (gb + i < got.size()) ? got[gb + i] : 8'hxx;
         check(tag, {24'd0, g}, {24'd0, exp_q[i]});
      end
   endtask

   initial begin
      int gb, db, k, len;
      logic [AW-1:0] rs;

      salt         = 8'($urandom);
      rst_n        = 1'b0;
      play         = 1'b0;
      pause        = 1'b0;
      stop         = 1'b0;
      loop_en      = 1'b0;
      sample_ready = 1'b1;
      start_addr   = TRACK0_START;
      end_addr     = TRACK0_END;
      step(2);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, sample_valid}, 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      step(1);

      // Plain playback of track 0
      gb = got.size();
      db = done_cnt;
      play_pulse();
      check("play_busy", {31'd0, busy}, 32'd1);
      step(3);
      check("pre_tick_valid", {31'd0, sample_valid}, 32'd0);
      step(1);
      check("first_valid", {31'd0, sample_valid}, 32'd1);
      check("first_data", {24'd0, sample_data}, 32'h55);
      wait_done("t2_done");
      check("t2_busy_fall", {31'd0, busy}, 32'd0);
      check("t2_last_data", {24'd0, sample_data}, 32'h85);
      step(1);
      check("t2_done_pulse", {31'd0, done}, 32'd0);
      check("t2_valid_drop", {31'd0, sample_valid}, 32'd0);
      build_exp(TRACK0_START, 6);
      check_seq("t2_seq", gb);
      check("t2_done_cnt", 32'(done_cnt - db), 32'd1);

      // Looping: seventh sample wraps to the start, no done
      loop_en = 1'b1;
      gb = got.size();
      db = done_cnt;
      play_pulse();
      k = 0;
      while (got.size() - gb < 7 && k < 200) begin
         step(1);
         k++;
      end
      check("t3_count", {31'd0, (got.size() - gb >= 7)}, 32'd1);
      check("t3_sixth", {24'd0, got[gb + 5]}, 32'h85);
      check("t3_seventh", {24'd0, got[gb + 6]}, 32'h55);
      check("t3_no_done", 32'(done_cnt - db), 32'd0);
      check("t3_busy", {31'd0, busy}, 32'd1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      loop_en = 1'b0;
      check("t3_stop_busy", {31'd0, busy}, 32'd0);
      check("t3_stop_valid", {31'd0, sample_valid}, 32'd0);

      // Backpressure over two ticks
      sample_ready = 1'b0;
      gb = got.size();
      play_pulse();
      step(4);
      check("t4_valid1", {31'd0, sample_valid}, 32'd1);
      check("t4_data1", {24'd0, sample_data}, 32'h55);
      check("t4_no_ovr", {31'd0, overrun}, 32'd0);
      step(4);
      check("t4_valid2", {31'd0, sample_valid}, 32'd1);
      check("t4_ovr", {31'd0, overrun}, 32'd1);
      check("t4_data2", {24'd0, sample_data}, 32'h5C);
      sample_ready = 1'b1;
      step(1);
      check("t4_accept_drop", {31'd0, sample_valid}, 32'd0);
      wait_done("t4_done");
      step(1);
      build_exp(TRACK0_START + 24'd1, 5);
      check_seq("t4_seq", gb);

      // Pause mid-track, then resume without skip or repeat
      gb = got.size();
      play_pulse();
      step(8);
      pause = 1'b1;
      step(1);
      check("t5_pause_addr", 32'(rom_addr), 32'd2);
      k = got.size();
      step(10);
      check("t5_addr_hold", 32'(rom_addr), 32'd2);
      check("t5_busy", {31'd0, busy}, 32'd1);
      check("t5_no_samples", 32'(got.size()), 32'(k));
      pause = 1'b0;
      play_pulse();
      wait_done("t5_done");
      step(1);
      build_exp(TRACK0_START, 6);
      check_seq("t5_seq", gb);

      // Stop coincident with the first tick, then a one-sample track
      gb = got.size();
      play_pulse();
      step(3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("t6_valid", {31'd0, sample_valid}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_no_sample", 32'(got.size() - gb), 32'd0);
      check("t6_ovr_sticky", {31'd0, overrun}, 32'd1);
      start_addr = TRACK1_START;
      end_addr   = TRACK1_END;
      play_pulse();
      wait_done("t6_done");
      check("t6_addr", 32'(rom_addr), 32'd20000);
      step(1);
      build_exp(TRACK1_START, 1);
      check_seq("t6_seq", gb);

      // Randomized tracks, half of them wrapping through address 0
      for (int it = 0; it < 6; it++) begin
         len = int'($urandom_range(1, 6));
         if (it % 2 == 0) rs = AW'(24'hFFFFFF - $urandom_range(0, 3));
         else rs = AW'($urandom_range(100, 60000));
         start_addr = rs;
         end_addr   = rs + AW'(len - 1);
         gb = got.size();
         db = done_cnt;
         play_pulse();
         step(int'($urandom_range(0, 2)));
         pause = 1'b1;
         step(int'($urandom_range(1, 8)));
         pause = 1'b0;
         play_pulse();
         wait_done("rnd_done");
         step(1);
         build_exp(rs, len);
         check_seq("rnd_seq", gb);
         check("rnd_done_cnt", 32'(done_cnt - db), 32'd1);
      end

      // Asynchronous reset in the middle of playback
      start_addr = 24'd3;
      end_addr   = 24'd5;
      play_pulse();
      step(6);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_addr", 32'(rom_addr), 32'd0);
      check("ar_data", {24'd0, sample_data}, 32'd0);
      check("ar_valid", {31'd0, sample_valid}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_done", {31'd0, done}, 32'd0);
      check("ar_ovr", {31'd0, overrun}, 32'd0);
      step(1);
      #2;
      rst_n = 1'b1;
      step(3);
      check("ar_idle", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
